// File: rtl/sipo_deser_if.sv
// Output-side handshake of the SIPO receiver: one buffered word with valid/ready.
interface sipo_deser_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] pdata;
  logic             pvalid;
  logic             pready;

  modport master (output pdata, output pvalid, input pready);
  modport slave  (input pdata, input pvalid, output pready);
endinterface

// File: rtl/sipo_deser.sv
// Serial-in parallel-out receiver: assembles WIDTH-bit words from si and
// offers them through a one-entry buffer, flagging a sticky overrun on drops.
module sipo_deser #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     si,
  input  logic                     si_en,
  input  logic                     abort,
  output logic                     busy,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overrun,
  input  logic                     clr_ovr,
  sipo_deser_if.master             p
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shifter;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_pdata;
  logic             r_pvalid;
  logic             r_overrun;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_next = r_shifter;
    if (MSB_FIRST) w_next = {r_shifter[WIDTH-2:0], si};
    else           w_next = {si, r_shifter[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_shifter <= '0;
      r_bit_cnt <= '0;
      r_pdata   <= '0;
      r_pvalid  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // Later assignments in this block override these defaults (load/set win).
      if (r_pvalid && p.pready) r_pvalid  <= 1'b0;
      if (clr_ovr)              r_overrun <= 1'b0;

      if (abort) begin
        r_state   <= IDLE;
        r_shifter <= '0;
        r_bit_cnt <= '0;
      end else if (si_en) begin
        r_shifter <= w_next;
        if (r_bit_cnt == LAST) begin
          r_state   <= IDLE;
          r_bit_cnt <= '0;
          if (!r_pvalid || p.pready) begin
            r_pdata  <= w_next;
            r_pvalid <= 1'b1;
          end else begin
            r_overrun <= 1'b1;
          end
        end else begin
          r_state   <= SHIFT;
          r_bit_cnt <= r_bit_cnt + CW'(1);
        end
      end
    end
  end

  assign busy     = (r_state == SHIFT);
  assign bit_cnt  = r_bit_cnt;
  assign overrun  = r_overrun;
  assign p.pdata  = r_pdata;
  assign p.pvalid = r_pvalid;
endmodule
